id_ex_latch: RTL and testbench
==============================

// Module: id_ex_latch
// PURPOSE
// - ID/EX pipeline register of the 5-stage pipelined CPU. It captures decode-stage operands,
//   immediates, register selects and control at each CLK edge.
// - Its outputs feed the ALU operand muxes and the forwarding unit in EX.
// - rdat_two_id_ex_output is the "no forward" (code 3'b000) input of the ALU B-operand mux.
// - Implements stall (hold), flush (bubble insert) and halt freeze.
// PARAMETERS
// - WORD_W  32  datapath word width
// - REG_W   5   register-select width
// - OP_W    4   ALU opcode width
// PORTS
// - CLK                    in   1       pipeline clock, rising edge
// - RST                    in   1       asynchronous reset, active-high
// - en                     in   1       load enable; 0 = stall (hold contents)
// - flush                  in   1       squash; insert bubble on next edge
// - valid_id               in   1       ID stage holds a real instruction
// - pc4_id                 in   WORD_W  PC+4 of ID instruction
// - rdat_one_id            in   WORD_W  register file port 1 data
// - rdat_two_id            in   WORD_W  register file port 2 data
// - imm_ext_id             in   WORD_W  sign/zero-extended imm16
// - upper16_id             in   WORD_W  {imm16,16'h0} for LUI
// - shamt_id               in   5       shift amount
// - aluop_id               in   OP_W    ALU opcode
// - alusrc_id              in   1       1 = B operand is immediate
// - rs_id, rt_id, wsel_id  in   REG_W   source/dest selects
// - regwrite_id            in   1       control bit
// - memread_id             in   1       control bit
// - memwrite_id            in   1       control bit
// - halt_id                in   1       control bit
// - *_id_ex_output         out  same    registered copy of each *_id input above, plus valid_id_ex_output
// - stall_cnt              out  32      stall-cycle counter (see CONFIGURATION)
// - flush_cnt              out  32      flush counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, RST=1): every output 0, including valid_id_ex_output and both counters.
//   Outputs stay 0 until the first CLK edge after RST deasserts.
// - Latency: 1 cycle. Inputs sampled at a rising CLK edge appear at the outputs after that edge.
//   No combinational path from inputs to outputs.
// - Per-edge priority: flush > frozen > !en > load.
//   - flush=1: bubble.
//     - valid, regwrite, memread, memwrite, halt, aluop, wsel <= 0.
//     - Data fields (pc4, rdat_one, rdat_two, imm_ext, upper16, shamt, rs, rt) <= 0.
//     - Flush overrides a simultaneous en=0 and clears the frozen state.
//   - frozen: halt_id_ex_output=1 && valid_id_ex_output=1. All fields hold regardless of en.
//     Only flush or RST exits the frozen state.
//   - en=0: all fields hold the previous value (stall). Repeated stalls hold indefinitely.
//   - en=1: all fields <= *_id inputs.
//     - If valid_id=0, control bits (regwrite, memread, memwrite, halt) load as 0.
//     - An invalid instruction never writes registers or memory.
// - Forwarding unit reads rs/rt/wsel/regwrite from these outputs.
//   - A bubble must present wsel=0 and regwrite=0 so that no forwarding is selected.
// - No arithmetic in the datapath; all fields are pure registers, widths unchanged.
// CONFIGURATION
// - ID_EX_PERF_EN defined:
//   - stall_cnt += 1 on each edge with en=0 && flush=0 && !frozen.
//   - flush_cnt += 1 on each edge with flush=1.
//   - Both counters saturate at 32'hFFFF_FFFF (no wrap).
//   - Both counters clear only on RST.
// - ID_EX_PERF_EN undefined: no counter flops; stall_cnt and flush_cnt tied to 32'h0.
// TESTING
// - Reset mid-run:
//   - Stimulus: load rdat_two_id=32'hDEAD_BEEF, regwrite=1, then assert RST between edges.
//   - Required: all outputs 0 immediately (no clock needed).
// - Load:
//   - Stimulus: en=1, valid_id=1, rdat_two_id=32'h1234_5678, wsel_id=5'd9, regwrite_id=1.
//   - Required after 1 edge: rdat_two_id_ex_output=32'h1234_5678, wsel=9, regwrite=1, valid=1.
// - Stall:
//   - Stimulus: after the load above, en=0 for 3 edges while inputs change to 32'h0.
//   - Required: outputs keep 32'h1234_5678. With ID_EX_PERF_EN, stall_cnt=3.
// - Flush vs stall:
//   - Stimulus: en=0 and flush=1 on the same edge.
//   - Required: valid=0, regwrite=0, wsel=0, rdat_two=0. With ID_EX_PERF_EN, flush_cnt=1 and stall_cnt unchanged.
// - Invalid load:
//   - Stimulus: en=1, valid_id=0, memwrite_id=1, regwrite_id=1.
//   - Required: memwrite_id_ex_output=0, regwrite_id_ex_output=0, valid=0.
// - Halt freeze:
//   - Stimulus: load valid halt_id=1, then en=1 with new data for 4 edges.
//   - Required: outputs unchanged, halt=1.
//   - Then flush=1: required halt=0, valid=0, and the next en=1 edge loads normally.

Source files
------------

// File: rtl/id_ex_latch.sv
// ---------------------------------------------------------------------------
// id_ex_latch
//
// ID/EX pipeline register of the 5-stage pipelined CPU. It captures the
// decode-stage operands, immediates, register selects and control bits on
// every rising CLK edge. It feeds the ALU operand muxes and the forwarding
// unit in EX. rdat_two_id_ex_output is the "no forward" input of the ALU
// B-operand mux.
//
// Per-edge priority: flush > frozen > stall (!en) > load.
//   flush  : insert a bubble. Every field clears, and the frozen state ends.
//   frozen : a valid halt is held in the register. Every field holds until
//            a flush or RST arrives.
//   !en    : stall. Every field holds.
//   load   : capture the *_id inputs. Control bits are gated by valid_id.
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   en                   load enable, 0 = stall
//   flush                squash: bubble on the next edge
//   valid_id             ID stage holds a real instruction
//   *_id                 decode-stage operands, selects and control bits
//   *_id_ex_output       registered copies of the *_id inputs
//   stall_cnt, flush_cnt performance counters
//
// Configuration
//   ID_EX_PERF_EN        When defined, stall_cnt and flush_cnt are
//                        saturating 32-bit counters that only RST clears.
//                        When undefined, both counters are tied to zero.
// ---------------------------------------------------------------------------
module id_ex_latch #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_id,
    input  logic [WORD_W-1:0] pc4_id,
    input  logic [WORD_W-1:0] rdat_one_id,
    input  logic [WORD_W-1:0] rdat_two_id,
    input  logic [WORD_W-1:0] imm_ext_id,
    input  logic [WORD_W-1:0] upper16_id,
    input  logic [4:0]        shamt_id,
    input  logic [OP_W-1:0]   aluop_id,
    input  logic              alusrc_id,
    input  logic [REG_W-1:0]  rs_id,
    input  logic [REG_W-1:0]  rt_id,
    input  logic [REG_W-1:0]  wsel_id,
    input  logic              regwrite_id,
    input  logic              memread_id,
    input  logic              memwrite_id,
    input  logic              halt_id,
    output logic              valid_id_ex_output,
    output logic [WORD_W-1:0] pc4_id_ex_output,
    output logic [WORD_W-1:0] rdat_one_id_ex_output,
    output logic [WORD_W-1:0] rdat_two_id_ex_output,
    output logic [WORD_W-1:0] imm_ext_id_ex_output,
    output logic [WORD_W-1:0] upper16_id_ex_output,
    output logic [4:0]        shamt_id_ex_output,
    output logic [OP_W-1:0]   aluop_id_ex_output,
    output logic              alusrc_id_ex_output,
    output logic [REG_W-1:0]  rs_id_ex_output,
    output logic [REG_W-1:0]  rt_id_ex_output,
    output logic [REG_W-1:0]  wsel_id_ex_output,
    output logic              regwrite_id_ex_output,
    output logic              memread_id_ex_output,
    output logic              memwrite_id_ex_output,
    output logic              halt_id_ex_output,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    // A valid halt that has reached EX freezes the register. Only a flush or
    // RST releases it.
    logic frozen;
    assign frozen = halt_id_ex_output & valid_id_ex_output;

    // NOTE: Sequential state uses non-blocking (<=) assignments so that every
    // flop samples its pre-edge value. Blocking assignments here would create
    // order-dependent races.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_id_ex_output    <= 1'b0;
            pc4_id_ex_output      <= '0;
            rdat_one_id_ex_output <= '0;
            rdat_two_id_ex_output <= '0;
            imm_ext_id_ex_output  <= '0;
            upper16_id_ex_output  <= '0;
            shamt_id_ex_output    <= '0;
            aluop_id_ex_output    <= '0;
            alusrc_id_ex_output   <= 1'b0;
            rs_id_ex_output       <= '0;
            rt_id_ex_output       <= '0;
            wsel_id_ex_output     <= '0;
            regwrite_id_ex_output <= 1'b0;
            memread_id_ex_output  <= 1'b0;
            memwrite_id_ex_output <= 1'b0;
            halt_id_ex_output     <= 1'b0;
        end else if (flush) begin
            // Bubble: wsel=0 and regwrite=0 keep the forwarding unit idle.
            valid_id_ex_output    <= 1'b0;
            pc4_id_ex_output      <= '0;
            rdat_one_id_ex_output <= '0;
            rdat_two_id_ex_output <= '0;
            imm_ext_id_ex_output  <= '0;
            upper16_id_ex_output  <= '0;
            shamt_id_ex_output    <= '0;
            aluop_id_ex_output    <= '0;
            alusrc_id_ex_output   <= 1'b0;
            rs_id_ex_output       <= '0;
            rt_id_ex_output       <= '0;
            wsel_id_ex_output     <= '0;
            regwrite_id_ex_output <= 1'b0;
            memread_id_ex_output  <= 1'b0;
            memwrite_id_ex_output <= 1'b0;
            halt_id_ex_output     <= 1'b0;
        end else if (en && !frozen) begin
            valid_id_ex_output    <= valid_id;
            pc4_id_ex_output      <= pc4_id;
            rdat_one_id_ex_output <= rdat_one_id;
            rdat_two_id_ex_output <= rdat_two_id;
            imm_ext_id_ex_output  <= imm_ext_id;
            upper16_id_ex_output  <= upper16_id;
            shamt_id_ex_output    <= shamt_id;
            aluop_id_ex_output    <= aluop_id;
            alusrc_id_ex_output   <= alusrc_id;
            rs_id_ex_output       <= rs_id;
            rt_id_ex_output       <= rt_id;
            wsel_id_ex_output     <= wsel_id;
            // An invalid instruction must never write registers or memory,
            // and it must never freeze the pipe.
            regwrite_id_ex_output <= valid_id & regwrite_id;
            memread_id_ex_output  <= valid_id & memread_id;
            memwrite_id_ex_output <= valid_id & memwrite_id;
            halt_id_ex_output     <= valid_id & halt_id;
        end
        // In every other case (frozen, or stalled with en=0) all fields hold.
    end

`ifdef ID_EX_PERF_EN
    // Saturating event counters. Only RST clears them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!en && !flush && !frozen && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// ---------------------------------------------------------------------------
// tb_id_ex_latch
//
// Directed testbench for id_ex_latch. One 32-bit "seed" word per vector
// drives every data field through a fixed, zero-preserving mapping, so a
// bubble (seed 0) expects every data field at zero.
// Build with +define+ID_EX_PERF_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_id_ex_latch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en, flush, valid_id;
    logic [31:0] pc4_id, rdat_one_id, rdat_two_id, imm_ext_id, upper16_id;
    logic [4:0]  shamt_id;
    logic [3:0]  aluop_id;
    logic        alusrc_id;
    logic [4:0]  rs_id, rt_id, wsel_id;
    logic        regwrite_id, memread_id, memwrite_id, halt_id;

    logic        valid_o;
    logic [31:0] pc4_o, rdat_one_o, rdat_two_o, imm_ext_o, upper16_o;
    logic [4:0]  shamt_o;
    logic [3:0]  aluop_o;
    logic        alusrc_o;
    logic [4:0]  rs_o, rt_o, wsel_o;
    logic        regwrite_o, memread_o, memwrite_o, halt_o;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    id_ex_latch dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .valid_id(valid_id),
        .pc4_id(pc4_id), .rdat_one_id(rdat_one_id), .rdat_two_id(rdat_two_id),
        .imm_ext_id(imm_ext_id), .upper16_id(upper16_id), .shamt_id(shamt_id),
        .aluop_id(aluop_id), .alusrc_id(alusrc_id), .rs_id(rs_id), .rt_id(rt_id),
        .wsel_id(wsel_id), .regwrite_id(regwrite_id), .memread_id(memread_id),
        .memwrite_id(memwrite_id), .halt_id(halt_id),
        .valid_id_ex_output(valid_o), .pc4_id_ex_output(pc4_o),
        .rdat_one_id_ex_output(rdat_one_o), .rdat_two_id_ex_output(rdat_two_o),
        .imm_ext_id_ex_output(imm_ext_o), .upper16_id_ex_output(upper16_o),
        .shamt_id_ex_output(shamt_o), .aluop_id_ex_output(aluop_o),
        .alusrc_id_ex_output(alusrc_o), .rs_id_ex_output(rs_o),
        .rt_id_ex_output(rt_o), .wsel_id_ex_output(wsel_o),
        .regwrite_id_ex_output(regwrite_o), .memread_id_ex_output(memread_o),
        .memwrite_id_ex_output(memwrite_o), .halt_id_ex_output(halt_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ctrl packing: {halt, memwrite, memread, regwrite}
    typedef struct packed {
        logic        en;
        logic        flush;
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic [4:0]  wsel;
        logic        e_valid;
        logic [3:0]  e_ctrl;
        logic [31:0] e_data;
        logic [4:0]  e_wsel;
        logic [31:0] e_stall;
        logic [31:0] e_flush;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic e, logic f, logic v, logic [3:0] c,
                                logic [31:0] d, logic [4:0] w, logic ev,
                                logic [3:0] ec, logic [31:0] ed, logic [4:0] ew,
                                logic [31:0] es, logic [31:0] ef);
        vec_t t;
        t.en = e; t.flush = f; t.valid = v; t.ctrl = c; t.data = d; t.wsel = w;
        t.e_valid = ev; t.e_ctrl = ec; t.e_data = ed; t.e_wsel = ew;
        t.e_stall = es; t.e_flush = ef;
        return t;
    endfunction

    // Zero-preserving mappings from the seed word to the secondary fields.
    function automatic logic [31:0] f_pc4(logic [31:0] r);
        return {r[15:0], r[31:16]};
    endfunction
    function automatic logic [31:0] f_one(logic [31:0] r);
        return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endfunction
    function automatic logic [31:0] f_imm(logic [31:0] r);
        return {r[30:0], r[31]};
    endfunction
    function automatic logic [31:0] f_up(logic [31:0] r);
        return {r[15:0], 16'h0};
    endfunction
    function automatic logic [31:0] f_misc(logic [31:0] r);
        // {shamt, aluop, alusrc, rs, rt}
        return {12'h0, r[4:0], r[8:5], r[31], r[13:9], r[18:14]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic v,
                         input logic [3:0] c, input logic [31:0] d, input logic [4:0] w);
        en = e; flush = f; valid_id = v;
        rdat_two_id = d; pc4_id = f_pc4(d); rdat_one_id = f_one(d);
        imm_ext_id = f_imm(d); upper16_id = f_up(d);
        shamt_id = d[4:0]; aluop_id = d[8:5]; alusrc_id = d[31];
        rs_id = d[13:9]; rt_id = d[18:14]; wsel_id = w;
        regwrite_id = c[0]; memread_id = c[1]; memwrite_id = c[2]; halt_id = c[3];
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [3:0] ec,
                             input logic [31:0] ed, input logic [4:0] ew,
                             input logic [31:0] es, input logic [31:0] ef);
        check({tag, " valid"}, {31'h0, valid_o}, {31'h0, ev});
        check({tag, " ctrl"}, {28'h0, halt_o, memwrite_o, memread_o, regwrite_o}, {28'h0, ec});
        check({tag, " wsel"}, {27'h0, wsel_o}, {27'h0, ew});
        check({tag, " rdat_two"}, rdat_two_o, ed);
        check({tag, " pc4"}, pc4_o, f_pc4(ed));
        check({tag, " rdat_one"}, rdat_one_o, f_one(ed));
        check({tag, " imm_ext"}, imm_ext_o, f_imm(ed));
        check({tag, " upper16"}, upper16_o, f_up(ed));
        check({tag, " misc"}, {12'h0, shamt_o, aluop_o, alusrc_o, rs_o, rt_o}, f_misc(ed));
`ifdef ID_EX_PERF_EN
        check({tag, " stall_cnt"}, stall_cnt, es);
        check({tag, " flush_cnt"}, flush_cnt, ef);
`else
        check({tag, " stall_cnt"}, stall_cnt, es & 32'h0);
        check({tag, " flush_cnt"}, flush_cnt, ef & 32'h0);
`endif
    endtask

    initial begin
        //              en fl v  ctrl     data           wsel   ev ectrl    edata          ewsel  stall flush
        vecs[0]  = mk(1, 0, 1, 4'b0001, 32'h1234_5678, 5'd9,  1, 4'b0001, 32'h1234_5678, 5'd9,  0, 0);
        vecs[1]  = mk(0, 0, 1, 4'b0000, 32'h0,         5'd0,  1, 4'b0001, 32'h1234_5678, 5'd9,  1, 0);
        vecs[2]  = mk(0, 0, 1, 4'b0000, 32'h0,         5'd0,  1, 4'b0001, 32'h1234_5678, 5'd9,  2, 0);
        vecs[3]  = mk(0, 0, 1, 4'b0000, 32'h0,         5'd0,  1, 4'b0001, 32'h1234_5678, 5'd9,  3, 0);
        vecs[4]  = mk(0, 1, 1, 4'b0001, 32'h5555_AAAA, 5'd6,  0, 4'b0000, 32'h0,         5'd0,  3, 1);
        vecs[5]  = mk(1, 0, 0, 4'b0101, 32'hA5A5_0F0F, 5'd3,  0, 4'b0000, 32'hA5A5_0F0F, 5'd3,  3, 1);
        vecs[6]  = mk(1, 0, 1, 4'b0010, 32'hCAFE_0001, 5'd31, 1, 4'b0010, 32'hCAFE_0001, 5'd31, 3, 1);
        vecs[7]  = mk(1, 0, 1, 4'b1001, 32'h0BAD_F00D, 5'd7,  1, 4'b1001, 32'h0BAD_F00D, 5'd7,  3, 1);
        vecs[8]  = mk(1, 0, 1, 4'b0001, 32'h1111_1111, 5'd2,  1, 4'b1001, 32'h0BAD_F00D, 5'd7,  3, 1);
        vecs[9]  = mk(1, 0, 1, 4'b0110, 32'h2222_2222, 5'd2,  1, 4'b1001, 32'h0BAD_F00D, 5'd7,  3, 1);
        vecs[10] = mk(1, 0, 1, 4'b0001, 32'h3333_3333, 5'd2,  1, 4'b1001, 32'h0BAD_F00D, 5'd7,  3, 1);
        vecs[11] = mk(0, 0, 1, 4'b0001, 32'h4444_4444, 5'd2,  1, 4'b1001, 32'h0BAD_F00D, 5'd7,  3, 1);
        vecs[12] = mk(1, 1, 1, 4'b0001, 32'h9999_9999, 5'd5,  0, 4'b0000, 32'h0,         5'd0,  3, 2);
        vecs[13] = mk(1, 0, 1, 4'b0001, 32'h7654_3210, 5'd4,  1, 4'b0001, 32'h7654_3210, 5'd4,  3, 2);
        vecs[14] = mk(1, 0, 0, 4'b1000, 32'h8000_00FF, 5'd8,  0, 4'b0000, 32'h8000_00FF, 5'd8,  3, 2);
        vecs[15] = mk(1, 0, 1, 4'b0011, 32'h1357_9BDF, 5'd12, 1, 4'b0011, 32'h1357_9BDF, 5'd12, 3, 2);
        vecs[16] = mk(0, 0, 1, 4'b1111, 32'hFFFF_FFFF, 5'd30, 1, 4'b0011, 32'h1357_9BDF, 5'd12, 4, 2);

        // Power-on reset, held across two edges.
        RST = 1'b1;
        drive(1, 0, 1, 4'b1111, 32'hFFFF_FFFF, 5'd31);
        #2;
        check_all("reset_async", 0, 4'b0, 32'h0, 5'd0, 0, 0);
        @(posedge CLK); @(posedge CLK); #1;
        check_all("reset_held", 0, 4'b0, 32'h0, 5'd0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].flush, vecs[i].valid, vecs[i].ctrl,
                  vecs[i].data, vecs[i].wsel);
            @(posedge CLK); #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ctrl,
                      vecs[i].e_data, vecs[i].e_wsel, vecs[i].e_stall, vecs[i].e_flush);
            @(negedge CLK);
        end

        // Reset mid-run: load, then assert RST between edges.
        drive(1, 0, 1, 4'b0001, 32'hDEAD_BEEF, 5'd17);
        @(posedge CLK); #1;
        check_all("pre_midreset", 1, 4'b0001, 32'hDEAD_BEEF, 5'd17, 4, 2);
        #1;
        RST = 1'b1;
        #1;
        check_all("midreset_async", 0, 4'b0, 32'h0, 5'd0, 0, 0);
        @(posedge CLK); #1;
        check_all("midreset_edge", 0, 4'b0, 32'h0, 5'd0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 0, 1, 4'b0101, 32'h0F1E_2D3C, 5'd21);
        #2;
        check_all("post_reset_noedge", 0, 4'b0, 32'h0, 5'd0, 0, 0);
        @(posedge CLK); #1;
        check_all("post_reset_load", 1, 4'b0101, 32'h0F1E_2D3C, 5'd21, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
